// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for fp_mult_pipe.
// The slave modport is the multiplier; the master modport is the producer/consumer side.
interface fp_mult_pipe_if #(
  parameter int EXPONENT = 8,
  parameter int MANTISSA = 23
) ();
  localparam int W = EXPONENT + MANTISSA + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_operand;
  logic [W-1:0] b_operand;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport slave (
    input  in_valid, a_operand, b_operand, out_ready,
    output in_ready, out_valid, result, flags
  );

  modport master (
    output in_valid, a_operand, b_operand, out_ready,
    input  in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier (classify, multiply, round/pack)
// with valid/ready backpressure, RNE rounding, flush-to-zero and exception flags.
module fp_mult_pipe #(
  parameter int EXPONENT = 8,
  parameter int MANTISSA = 23
) (
  input  logic          clk,
  input  logic          rst,
  fp_mult_pipe_if.slave bus
);
  localparam int E  = EXPONENT;
  localparam int M  = MANTISSA;
  localparam int W  = E + M + 1;
  localparam int XW = E + 2;
  localparam logic [XW-1:0] BIAS     = XW'(2**(E-1) - 1);
  localparam logic [XW-1:0] ES_MAX   = XW'(2**E - 1);
  localparam logic [E-1:0]  EXP_ONES = '1;
  localparam logic [W-1:0]  QNAN     = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_e;

  logic v1_q, v2_q, v3_q;
  logic ready1, ready2, ready3;

  assign ready3        = !v3_q || bus.out_ready;
  assign ready2        = !v2_q || ready3;
  assign ready1        = !v1_q || ready2;
  assign bus.in_ready  = ready1;
  assign bus.out_valid = v3_q;

  // Stage 1: unpack and classify
  logic [E-1:0] ea, eb;
  logic [M-1:0] fa, fb;
  logic         a_zero, a_inf, a_nan, a_snan;
  logic         b_zero, b_inf, b_nan, b_snan;
  logic         inf_x_zero;
  special_e     sp1_d;
  logic         inv1_d;
  logic [XW-1:0] es1_d;

  assign ea = bus.a_operand[W-2 -: E];
  assign fa = bus.a_operand[M-1:0];
  assign eb = bus.b_operand[W-2 -: E];
  assign fb = bus.b_operand[M-1:0];

  always_comb begin
    a_zero     = (ea == '0);
    a_inf      = (ea == EXP_ONES) && (fa == '0);
    a_nan      = (ea == EXP_ONES) && (fa != '0);
    a_snan     = a_nan && !fa[M-1];
    b_zero     = (eb == '0);
    b_inf      = (eb == EXP_ONES) && (fb == '0);
    b_nan      = (eb == EXP_ONES) && (fb != '0);
    b_snan     = b_nan && !fb[M-1];
    inf_x_zero = (a_inf && b_zero) || (a_zero && b_inf);
    inv1_d     = a_snan || b_snan || inf_x_zero;
    es1_d      = {2'b00, ea} + {2'b00, eb} - BIAS;
    sp1_d      = SP_NONE;
    if (a_nan || b_nan || inf_x_zero) sp1_d = SP_NAN;
    else if (a_inf || b_inf)          sp1_d = SP_INF;
    else if (a_zero || b_zero)        sp1_d = SP_ZERO;
  end

  logic          sign1_q, inv1_q;
  special_e      sp1_q;
  logic [XW-1:0] es1_q;
  logic [M:0]    siga1_q, sigb1_q;

  // Stage 2: significand multiply
  logic [2*M+1:0] prod2_d;
  assign prod2_d = {{(M+1){1'b0}}, siga1_q} * {{(M+1){1'b0}}, sigb1_q};

  logic           sign2_q, inv2_q;
  special_e       sp2_q;
  logic [XW-1:0]  es2_q;
  logic [2*M+1:0] prod2_q;

  // Stage 3: normalise, round to nearest even, resolve specials
  logic          hi, guard, sticky, rnd, ovf, unf;
  logic [M-1:0]  keep;
  logic [M:0]    kr;
  logic [XW-1:0] es_n;
  logic [W-1:0]  result_d;
  logic [3:0]    flags_d;

  always_comb begin
    hi = prod2_q[2*M+1];
    if (hi) begin
      keep   = prod2_q[2*M:M+1];
      guard  = prod2_q[M];
      sticky = |prod2_q[M-1:0];
    end else begin
      keep   = prod2_q[2*M-1:M];
      guard  = prod2_q[M-1];
      sticky = |prod2_q[M-2:0];
    end
    rnd  = guard && (sticky || keep[0]);
    kr   = {1'b0, keep} + {{M{1'b0}}, rnd};
    es_n = es2_q + XW'(hi) + XW'(kr[M]);
    ovf  = !es_n[XW-1] && (es_n >= ES_MAX);
    unf  = es_n[XW-1] || (es_n == '0);

    result_d = {sign2_q, es_n[E-1:0], kr[M-1:0]};
    flags_d  = {3'b000, guard | sticky};
    case (sp2_q)
      SP_NAN: begin
        result_d = QNAN;
        flags_d  = {inv2_q, 3'b000};
      end
      SP_INF: begin
        result_d = {sign2_q, EXP_ONES, {M{1'b0}}};
        flags_d  = 4'b0000;
      end
      SP_ZERO: begin
        result_d = {sign2_q, {(W-1){1'b0}}};
        flags_d  = 4'b0000;
      end
      default: begin
        if (ovf) begin
          result_d = {sign2_q, EXP_ONES, {M{1'b0}}};
          flags_d  = 4'b0101;
        end else if (unf) begin
          result_d = {sign2_q, {(W-1){1'b0}}};
          flags_d  = 4'b0011;
        end
      end
    endcase
  end

  logic [W-1:0] result_q;
  logic [3:0]   flags_q;

  assign bus.result = result_q;
  assign bus.flags  = flags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      sign1_q  <= 1'b0;
      inv1_q   <= 1'b0;
      sp1_q    <= SP_NONE;
      es1_q    <= '0;
      siga1_q  <= '0;
      sigb1_q  <= '0;
      sign2_q  <= 1'b0;
      inv2_q   <= 1'b0;
      sp2_q    <= SP_NONE;
      es2_q    <= '0;
      prod2_q  <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (ready1) begin
        v1_q <= bus.in_valid;
        if (bus.in_valid) begin
          sign1_q <= bus.a_operand[W-1] ^ bus.b_operand[W-1];
          inv1_q  <= inv1_d;
          sp1_q   <= sp1_d;
          es1_q   <= es1_d;
          siga1_q <= {1'b1, fa};
          sigb1_q <= {1'b1, fb};
        end
      end
      if (ready2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          sign2_q <= sign1_q;
          inv2_q  <= inv1_q;
          sp2_q   <= sp1_q;
          es2_q   <= es1_q;
          prod2_q <= prod2_d;
        end
      end
      if (ready3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          result_q <= result_d;
          flags_q  <= flags_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe: FP32 and BF16 instances, directed vectors,
// backpressure, stall stability and asynchronous reset flush.
module tb_fp_mult_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_mult_pipe_if #(.EXPONENT(8), .MANTISSA(23)) bus32 ();
  fp_mult_pipe_if #(.EXPONENT(8), .MANTISSA(7))  bus16 ();

  fp_mult_pipe #(.EXPONENT(8), .MANTISSA(23)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  fp_mult_pipe #(.EXPONENT(8), .MANTISSA(7))  dut16 (.clk(clk), .rst(rst), .bus(bus16));

  typedef struct { logic [31:0] res; logic [3:0] flg; } exp32_t;
  typedef struct { logic [15:0] res; logic [3:0] flg; } exp16_t;

  exp32_t q32[$];
  exp16_t q16[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_pop32  = 0;
  int n_pop16  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [3:0] f);
    bit acc = 1'b0;
    bus32.a_operand = a;
    bus32.b_operand = b;
    bus32.in_valid  = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = bus32.in_ready;
      @(posedge clk);
      #1;
    end
    if (acc) q32.push_back('{r, f});
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout32: operand %h not accepted, expected acceptance", a);
    end
    bus32.in_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] r, input logic [3:0] f);
    bit acc = 1'b0;
    bus16.a_operand = a;
    bus16.b_operand = b;
    bus16.in_valid  = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = bus16.in_ready;
      @(posedge clk);
      #1;
    end
    if (acc) q16.push_back('{r, f});
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout16: operand %h not accepted, expected acceptance", a);
    end
    bus16.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (q32.size() != 0 || q16.size() != 0); i++) @(posedge clk);
    #1;
    check("drain32_left", q32.size(), 0);
    check("drain16_left", q16.size(), 0);
  endtask

  // FP32 monitor: pops on every transfer and checks the output holds while stalled.
  logic [31:0] held_res;
  logic [3:0]  held_flg;
  bit          stall_hold = 1'b0;
  always @(negedge clk) begin
    exp32_t e;
    if (rst) stall_hold = 1'b0;
    else if (bus32.out_valid) begin
      if (stall_hold) begin
        check("stall_result", bus32.result, held_res);
        check("stall_flags", {28'd0, bus32.flags}, {28'd0, held_flg});
      end
      if (bus32.out_ready) begin
        stall_hold = 1'b0;
        if (q32.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected32: got %h, expected no output", bus32.result);
        end else begin
          e = q32.pop_front();
          check("result32", bus32.result, e.res);
          check("flags32", {28'd0, bus32.flags}, {28'd0, e.flg});
          n_pop32++;
        end
      end else begin
        stall_hold = 1'b1;
        held_res   = bus32.result;
        held_flg   = bus32.flags;
      end
    end else stall_hold = 1'b0;
  end

  always @(negedge clk) begin
    exp16_t e;
    if (!rst && bus16.out_valid && bus16.out_ready) begin
      if (q16.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected16: got %h, expected no output", bus16.result);
      end else begin
        e = q16.pop_front();
        check("result16", {16'd0, bus16.result}, {16'd0, e.res});
        check("flags16", {28'd0, bus16.flags}, {28'd0, e.flg});
        n_pop16++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops_before;
    bus32.in_valid = 1'b0; bus32.a_operand = '0; bus32.b_operand = '0; bus32.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a_operand = '0; bus16.b_operand = '0; bus16.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", bus32.out_valid, 0);
    check("rst_in_ready", bus32.in_ready, 1);
    check("rst_result", bus32.result, 0);
    check("rst_flags", bus32.flags, 0);

    // Directed FP32 products, consumer always ready
    send32(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    send32(32'h3F800800, 32'h3F800800, 32'h3F801000, 4'b0001);
    send32(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    send32(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    send32(32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    send32(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    send32(32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
    send32(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
    send32(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
    send32(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000);
    drain();

    // Backpressure: three fill the pipe, the rest wait for the consumer
    pops_before = n_pop32;
    bus32.out_ready = 1'b0;
    send32(32'h3F800000, 32'h40000000, 32'h40000000, 4'b0000);
    send32(32'h3F800000, 32'h40400000, 32'h40400000, 4'b0000);
    send32(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
    @(negedge clk);
    check("bp_in_ready_low", bus32.in_ready, 0);
    check("bp_out_valid", bus32.out_valid, 1);
    fork
      begin
        send32(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
        send32(32'h40400000, 32'h40400000, 32'h41100000, 4'b0000);
        send32(32'h3F000000, 32'h3F000000, 32'h3E800000, 4'b0000);
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus32.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_pop32 - pops_before, 6);

    // Asynchronous reset with three items in flight
    bus32.out_ready = 1'b0;
    send32(32'h3F800000, 32'h40000000, 32'h40000000, 4'b0000);
    send32(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
    send32(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", bus32.out_valid, 0);
    check("arst_result", bus32.result, 0);
    q32.delete();
    pops_before = n_pop32;
    @(posedge clk);
    #2 rst = 1'b0;
    bus32.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("arst_no_stale", n_pop32 - pops_before, 0);
    check("arst_idle_valid", bus32.out_valid, 0);

    // BF16 instance
    send16(16'h3FC0, 16'h4000, 16'h4040, 4'b0000);
    send16(16'h3F80, 16'hBF80, 16'hBF80, 4'b0000);
    drain();
    check("bf16_count", n_pop16, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
